// File: rtl/pixel_mem_arbiter.sv
// Frame-memory port arbiter: display reads own every read slot, queued writes
// drain through a small FIFO in the remaining cycles.
//   state   | meaning
//   IDLE    | port unused, mem_we = 0
//   READ    | display read slot, address from hcount/vcount
//   WRITE   | FIFO head popped onto the port, mem_we = 1
module pixel_mem_arbiter #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pix_value,
  output logic              sd,
  output logic [2:0]        fifo_level
);

  localparam int unsigned IMG_W_U  = IMG_W;
  localparam int unsigned IMG_H_U  = IMG_H;
  localparam int unsigned IMG_SIZE = IMG_W * IMG_H;
  localparam int          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  SUB_MASK = 10'((1 << SCALE_LOG2) - 1);
  localparam logic [2:0]  FULL_LVL = 3'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              active, slot, in_img, in_range, push, pop;
  logic [9:0]        img_row, img_col;
  logic [ADDR_W-1:0] rd_addr;

  logic              in_img_q, in_img_d;
  logic [7:0]        pix_q, pix_d;
  logic [1:0]        sd_pipe_q, sd_pipe_d;
  logic              wr_err_q, wr_err_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [7:0]        fifo_data_q [FIFO_DEPTH];
  logic [7:0]        fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]        count_q, count_d;

  assign img_row  = vcount >> SCALE_LOG2;
  assign img_col  = hcount >> SCALE_LOG2;
  assign in_img   = (32'(img_row) < IMG_H_U) && (32'(img_col) < IMG_W_U);
  assign rd_addr  = ADDR_W'(32'(img_row) * IMG_W_U + 32'(img_col));
  assign active   = (hcount < H_ACT) && (vcount < V_ACT);
  assign slot     = active && ((hcount & SUB_MASK) == 10'd0);
  assign in_range = 32'(wr_addr) < IMG_SIZE;

  assign wr_ready   = (count_q != FULL_LVL);
  assign push       = wr_req && wr_ready && in_range;
  assign pop        = (state_d == S_WRITE);
  assign fifo_level = count_q;
  assign wr_err     = wr_err_q;
  assign pix_value  = pix_q;
  assign sd         = sd_pipe_q[1];

  // State is decided combinationally every cycle so the read address goes out
  // in the slot itself; the registered copy marks the following capture cycle.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    if (!rst)                 state_d = S_IDLE;
    else if (slot)            state_d = S_READ;
    else if (count_q != 3'd0) state_d = S_WRITE;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_d)
      S_READ:  mem_addr = in_img ? rd_addr : '0;
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = fifo_addr_q[rd_ptr_q];
        mem_wdata = fifo_data_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  always_comb begin
    in_img_d  = slot && in_img;
    sd_pipe_d = {sd_pipe_q[0], ~active};
    wr_err_d  = wr_req && wr_ready && !in_range;
    pix_d     = pix_q;
    if (state_q == S_READ) pix_d = in_img_q ? mem_rdata : 8'd0;
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = wr_addr;
      fifo_data_d[wr_ptr_q] = wr_data;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    count_d = count_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_img_q  <= 1'b0;
      pix_q     <= 8'd0;
      sd_pipe_q <= 2'b11;
      wr_err_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 3'd0;
    end else begin
      in_img_q  <= in_img_d;
      pix_q     <= pix_d;
      sd_pipe_q <= sd_pipe_d;
      wr_err_q  <= wr_err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Entry storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Scoreboard bench for pixel_mem_arbiter: a cycle-level reference model queues
// expected writes and pixels; a monitor compares whenever the DUT presents them.
module tb_pixel_mem_arbiter;
  localparam int IMG_W = 160, IMG_SIZE = 19200, DEPTH = 4, H_TOT = 660;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcount, vcount;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready, wr_err, mem_we, sd;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, pix_value;
  logic [2:0]  fifo_level;

  always #5 clk = ~clk;

  pixel_mem_arbiter dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_err(wr_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .pix_value(pix_value), .sd(sd), .fifo_level(fifo_level)
  );

  // Frame memory: preloaded with addr[7:0], read data one cycle after address.
  logic [7:0] mem_model [0:32767];
  logic [7:0] rdata_q;
  bit         mem_init = 1'b0;
  assign mem_rdata = rdata_q;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32768; i++) mem_model[i] = 8'(i);
      mem_init = 1'b1;
    end
    rdata_q <= mem_model[mem_addr];
    if (mem_we) mem_model[mem_addr] = mem_wdata;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int c; bit sd; int pix; } px_t;
  wr_t exp_wr[$];
  px_t exp_px[$];

  int  cyc = 0, lvl = 0, e_raddr = 0, e_lvl = 0, held_pix = 0;
  bit  err_pend = 0, e_err = 0, e_ready = 0, e_we = 0, e_slot = 0, e_rst_low = 0, req_done = 0;

  // Reference model: FIFO occupancy as an integer, reads as image lookups.
  always @(negedge clk) begin
    bit act, slt, ready, psh, pp;
    act   = (hcount < 640) && (vcount < 480);
    slt   = act && (hcount % 4 == 0);
    ready = (lvl != DEPTH);
    e_ready   = ready;
    e_lvl     = lvl;
    e_err     = err_pend;
    e_rst_low = !rst;
    e_slot    = rst && slt;
    e_raddr   = (int'(vcount) / 4) * IMG_W + int'(hcount) / 4;
    pp        = rst && !slt && lvl > 0;
    e_we      = pp;
    psh       = rst && wr_req && ready && int'(wr_addr) < IMG_SIZE;
    req_done  = rst && wr_req && ready;
    err_pend  = rst && wr_req && ready && int'(wr_addr) >= IMG_SIZE;
    if (psh) exp_wr.push_back('{int'(wr_addr), int'(wr_data)});
    if (!rst) begin
      exp_wr.delete();
      lvl = 0;
      held_pix = 0;
      foreach (exp_px[i]) if (exp_px[i].c > cyc) begin exp_px[i].sd = 1; exp_px[i].pix = 0; end
      exp_px.push_back('{cyc + 2, 1'b1, 0});
    end else begin
      lvl = lvl + int'(psh) - int'(pp);
      if (slt) held_pix = int'(mem_model[e_raddr]);
      exp_px.push_back('{cyc + 2, !act, held_pix});
    end
  end

  always @(negedge clk) begin
    wr_t w;
    px_t p;
    #1;
    if (cyc >= 1) begin
      if (e_rst_low) begin
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
      end
      chk("wr_ready", int'(wr_ready), int'(e_ready));
      chk("fifo_level", int'(fifo_level), e_lvl);
      chk("wr_err", int'(wr_err), int'(e_err));
      chk("mem_we", int'(mem_we), int'(e_we));
      if (e_slot) chk("rd_addr", int'(mem_addr), e_raddr);
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wr_unexpected: got write addr %0d, expected none", mem_addr);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", int'(mem_addr), w.addr);
          chk("wr_data", int'(mem_wdata), w.data);
        end
      end
      while (exp_px.size() > 0 && exp_px[0].c < cyc) void'(exp_px.pop_front());
      if (exp_px.size() > 0 && exp_px[0].c == cyc) begin
        p = exp_px.pop_front();
        chk("sd", int'(sd), int'(p.sd));
        chk("pix_value", int'(pix_value), p.pix);
      end
    end
    cyc++;
  end

  task automatic run_line(int v, int ncyc, int wr_pct, int rst_at);
    for (int h = 0; h < ncyc; h++) begin
      @(posedge clk); #1;
      if (req_done) wr_req = 1'b0;
      hcount = 10'(h);
      vcount = 10'(v);
      if (h == rst_at)     rst = 1'b0;
      if (h == rst_at + 2) rst = 1'b1;
      if (!wr_req && $urandom_range(99) < wr_pct) begin
        wr_req  = 1'b1;
        wr_addr = ($urandom_range(15) == 0) ? 15'($urandom_range(32767, IMG_SIZE))
                                             : 15'($urandom_range(IMG_SIZE - 1));
        wr_data = 8'($urandom);
      end
    end
  endtask

  initial begin
    rst = 1'b0; hcount = '0; vcount = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Directed sweep at vcount = 4: image pixels 160 then 161.
    for (int h = 0; h < 8; h++) begin
      @(posedge clk); #1;
      hcount = 10'(h); vcount = 10'd4;
      @(negedge clk);
      if (h >= 2 && h <= 5) chk("sweep_pix_a0", int'(pix_value), 8'hA0);
      if (h >= 6)           chk("sweep_pix_a1", int'(pix_value), 8'hA1);
    end

    // Out-of-range request during blanking.
    @(posedge clk); #1;
    hcount = 10'd0; vcount = 10'd500; wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 8'h55;
    @(posedge clk); #1 wr_req = 1'b0;
    @(negedge clk);
    chk("oor_err_pulse", int'(wr_err), 1);
    chk("oor_level", int'(fifo_level), 0);
    @(posedge clk);
    @(negedge clk);
    chk("oor_err_clear", int'(wr_err), 0);

    run_line(500, 30, 100, -1);
    for (int i = 0; i < 14; i++) begin
      int v;
      v = (i % 4 == 3) ? 480 + $urandom_range(40) : $urandom_range(479);
      run_line(v, H_TOT, 40 + $urandom_range(55), (i == 6 || i == 11) ? 300 : -1);
    end
    run_line(500, 20, 0, -1);
    @(negedge clk); #2;
    chk("drain_empty", exp_wr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
